// File: rtl/sw_array_seq_pkg.sv
// ----------------------------------------------------------------------------
// sw_pkg : shared types and defaults for the SW systolic-array sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sw_pkg;

  localparam int SW_NUM_PE      = 8;
  localparam int SW_SCORE_WIDTH = 10;
  localparam int SW_REF_LEN_W   = 16;

  typedef enum logic [1:0] {
    BASE_A = 2'b00,
    BASE_C = 2'b01,
    BASE_G = 2'b10,
    BASE_T = 2'b11
  } base_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sw_array_seq_tracker.sv
// ----------------------------------------------------------------------------
// sw_max_tracker : best last-PE score, its reference index, and sample counter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sw_max_tracker
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = SW_SCORE_WIDTH,
  parameter int REF_LEN_W   = SW_REF_LEN_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   sample_en,
  input  logic [SCORE_WIDTH-1:0] V,
  output logic [SCORE_WIDTH-1:0] max_score,
  output logic [REF_LEN_W-1:0]   max_pos,
  output logic [REF_LEN_W-1:0]   sample_cnt
);

  logic [SCORE_WIDTH-1:0] max_score_q, max_score_d;
  logic [REF_LEN_W-1:0]   max_pos_q,   max_pos_d;
  logic [REF_LEN_W-1:0]   idx_q,       idx_d;

  always_comb begin
    max_score_d = max_score_q;
    max_pos_d   = max_pos_q;
    idx_d       = idx_q;
    if (clear) begin
      max_score_d = '0;
      max_pos_d   = '0;
      idx_d       = '0;
    end else if (sample_en) begin
      // Strictly greater only, so the earliest reference index wins a tie.
      if (V > max_score_q) begin
        max_score_d = V;
        max_pos_d   = idx_q;
      end
      idx_d = idx_q + REF_LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_score_q <= '0;
      max_pos_q   <= '0;
      idx_q       <= '0;
    end else begin
      max_score_q <= max_score_d;
      max_pos_q   <= max_pos_d;
      idx_q       <= idx_d;
    end
  end

  assign max_score  = max_score_q;
  assign max_pos    = max_pos_q;
  assign sample_cnt = idx_q;

endmodule

`default_nettype wire

// File: rtl/sw_array_seq.sv
// ----------------------------------------------------------------------------
// sw_array_seq : loads the read, streams the reference and drains a SW PE chain
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sw_array_seq
  import sw_pkg::*;
#(
  parameter int NUM_PE      = SW_NUM_PE,
  parameter int SCORE_WIDTH = SW_SCORE_WIDTH,
  parameter int REF_LEN_W   = SW_REF_LEN_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [REF_LEN_W-1:0]   ref_len,
  input  logic                   rd_valid,
  input  logic [1:0]             rd_base,
  output logic                   rd_ready,
  input  logic                   ref_valid,
  input  logic [1:0]             ref_base,
  output logic                   ref_ready,
  output logic [1:0]             arr_S,
  output logic                   arr_store_S,
  output logic [1:0]             arr_T,
  output logic                   arr_init,
  output logic [SCORE_WIDTH-1:0] arr_V_in,
  output logic [SCORE_WIDTH-1:0] arr_F_in,
  output logic                   arr_stall,
  input  logic [SCORE_WIDTH-1:0] arr_V_last,
  input  logic                   arr_init_last,
  output logic                   busy,
  output logic                   done,
  output logic [SCORE_WIDTH-1:0] max_score,
  output logic [REF_LEN_W-1:0]   max_pos
);

  localparam int                    LOAD_CNT_W = $clog2(NUM_PE + 1);
  localparam logic [LOAD_CNT_W-1:0] LOAD_LAST  = LOAD_CNT_W'(NUM_PE - 1);

  state_t                state_q,   state_d;
  logic [REF_LEN_W-1:0]  ref_len_q, ref_len_d;
  logic [LOAD_CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [REF_LEN_W-1:0]  ref_cnt_q, ref_cnt_d;
  base_t                 s_hold_q,  s_hold_d;
  base_t                 t_hold_q,  t_hold_d;

  logic                  trk_clear;
  logic                  sample_en;
  logic [REF_LEN_W-1:0]  sample_cnt;

  always_comb begin
    state_d     = state_q;
    ref_len_d   = ref_len_q;
    load_cnt_d  = load_cnt_q;
    ref_cnt_d   = ref_cnt_q;
    s_hold_d    = s_hold_q;
    t_hold_d    = t_hold_q;
    trk_clear   = 1'b0;
    rd_ready    = 1'b0;
    ref_ready   = 1'b0;
    arr_S       = 2'b00;
    arr_store_S = 1'b0;
    arr_T       = 2'b00;
    arr_init    = 1'b0;
    arr_stall   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          ref_len_d  = ref_len;
          load_cnt_d = '0;
          ref_cnt_d  = '0;
          s_hold_d   = BASE_A;
          t_hold_d   = BASE_A;
          trk_clear  = 1'b1;
        end
      end

      ST_LOAD: begin
        rd_ready    = 1'b1;
        arr_store_S = 1'b1;
        if (rd_valid) begin
          arr_S      = rd_base;
          s_hold_d   = base_t'(rd_base);
          load_cnt_d = load_cnt_q + LOAD_CNT_W'(1);
          if (load_cnt_q == LOAD_LAST) begin
            state_d = (ref_len_q == '0) ? ST_DONE : ST_STREAM;
          end
        end else begin
          // Missing read base: freeze the S chain with the last base presented.
          arr_S     = s_hold_q;
          arr_stall = 1'b1;
        end
      end

      ST_STREAM: begin
        ref_ready = 1'b1;
        arr_init  = 1'b1;
        if (ref_valid) begin
          arr_T     = ref_base;
          t_hold_d  = base_t'(ref_base);
          ref_cnt_d = ref_cnt_q + REF_LEN_W'(1);
          if (ref_cnt_q + REF_LEN_W'(1) == ref_len_q) begin
            state_d = ST_DRAIN;
          end
        end else begin
          arr_T     = t_hold_q;
          arr_stall = 1'b1;
        end
      end

      ST_DRAIN: begin
        if (sample_cnt == ref_len_q) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ref_len_q  <= '0;
      load_cnt_q <= '0;
      ref_cnt_q  <= '0;
      s_hold_q   <= BASE_A;
      t_hold_q   <= BASE_A;
    end else begin
      state_q    <= state_d;
      ref_len_q  <= ref_len_d;
      load_cnt_q <= load_cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      s_hold_q   <= s_hold_d;
      t_hold_q   <= t_hold_d;
    end
  end

  // Last-PE outputs only matter while reference data is in flight.
  assign sample_en = arr_init_last && !arr_stall &&
                     ((state_q == ST_STREAM) || (state_q == ST_DRAIN));

  sw_max_tracker #(
    .SCORE_WIDTH (SCORE_WIDTH),
    .REF_LEN_W   (REF_LEN_W)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .clear      (trk_clear),
    .sample_en  (sample_en),
    .V          (arr_V_last),
    .max_score  (max_score),
    .max_pos    (max_pos),
    .sample_cnt (sample_cnt)
  );

  assign busy     = (state_q == ST_LOAD) || (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);
  assign arr_V_in = '0;
  assign arr_F_in = '0;

endmodule

`default_nettype wire

// File: tb/tb_sw_array_seq.sv
// ----------------------------------------------------------------------------
// tb_sw_array_seq : directed bench for sw_array_seq with a small PE-chain model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sw_array_seq;

  localparam int NUM_PE = 8;
  localparam int SW     = 10;
  localparam int RW     = 16;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [RW-1:0] ref_len;
  logic          rd_valid, rd_ready, ref_valid, ref_ready;
  logic [1:0]    rd_base, ref_base, arr_S, arr_T;
  logic          arr_store_S, arr_init, arr_stall, arr_init_last, busy, done;
  logic [SW-1:0] arr_V_in, arr_F_in, arr_V_last, max_score;
  logic [RW-1:0] max_pos;

  always #5 clk = ~clk;

  sw_array_seq #(.NUM_PE(NUM_PE), .SCORE_WIDTH(SW), .REF_LEN_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .ref_len(ref_len),
    .rd_valid(rd_valid), .rd_base(rd_base), .rd_ready(rd_ready),
    .ref_valid(ref_valid), .ref_base(ref_base), .ref_ready(ref_ready),
    .arr_S(arr_S), .arr_store_S(arr_store_S), .arr_T(arr_T), .arr_init(arr_init),
    .arr_V_in(arr_V_in), .arr_F_in(arr_F_in), .arr_stall(arr_stall),
    .arr_V_last(arr_V_last), .arr_init_last(arr_init_last),
    .busy(busy), .done(done), .max_score(max_score), .max_pos(max_pos)
  );

  // Behavioural PE chain: NUM_PE stages that freeze on stall; V per issued beat from vtab.
  logic [SW-1:0]     vtab [8];
  int                vidx;
  logic [NUM_PE-1:0] pi;
  logic [SW-1:0]     pv [NUM_PE];

  always @(posedge clk) begin
    if (rst) begin
      pi   <= '0;
      vidx <= 0;
      for (int k = 0; k < NUM_PE; k++) pv[k] <= '0;
    end else begin
      if (start && !busy) vidx <= 0;
      else if (arr_init && !arr_stall) vidx <= vidx + 1;
      if (!arr_stall) begin
        pi <= {pi[NUM_PE-2:0], arr_init};
        for (int k = NUM_PE - 1; k > 0; k--) pv[k] <= pv[k-1];
        pv[0] <= (arr_init && vidx < 8) ? vtab[vidx[2:0]] : '0;
      end
    end
  end

  assign arr_init_last = pi[NUM_PE-1];
  assign arr_V_last    = pv[NUM_PE-1];

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;
  int         t0;
  int         done_seen;
  logic [1:0] rd [8];
  logic [1:0] rf [8];

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_done(input int exp_cyc, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 1);
    check({tag, "_done_cycle"}, cyc - t0, exp_cyc - t0);
    check({tag, "_busy_at_done"}, 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b1; ref_len = 16'd8;
    rd_valid = 1'b0; rd_base = 2'd0; ref_valid = 1'b0; ref_base = 2'd0;
    vtab = '{3, 7, 2, 7, 1, 0, 6, 5};
    tick(); tick();
    check("rst_ctrl", 32'({busy, done, rd_ready, ref_ready}), 0);
    check("rst_arr", 32'({arr_S, arr_store_S, arr_T, arr_init, arr_stall}), 0);
    check("rst_max", 32'(max_score) + 32'(max_pos) + 32'(arr_V_in) + 32'(arr_F_in), 0);

    // Job A: ref_len=8, clean load, two-cycle stream gap after beat 3.
    rst = 1'b0; t0 = cyc;
    tick(); start = 1'b0;
    check("A_load_entry", 32'({busy, rd_ready}), 3);
    rd = '{0, 1, 0, 1, 3, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      rd_valid = 1'b1; rd_base = rd[7-i]; #1;
      check("A_load_S", 32'(arr_S), 32'(rd[7-i]));
      check("A_load_ctl", 32'({rd_ready, arr_store_S, arr_stall}), 6);
      tick();
    end
    rd_valid = 1'b0;
    rf = '{0, 1, 0, 2, 0, 1, 3, 0};
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        for (int g = 0; g < 2; g++) begin
          ref_valid = 1'b0; ref_base = 2'd3; #1;
          check("A_gap_T", 32'(arr_T), 32'(rf[2]));
          check("A_gap_ctl", 32'({arr_stall, arr_init, ref_ready}), 7);
          tick();
        end
      end
      ref_valid = 1'b1; ref_base = rf[i]; #1;
      check("A_stream_T", 32'(arr_T), 32'(rf[i]));
      check("A_stream_ctl", 32'({arr_stall, arr_init, ref_ready, arr_store_S}), 6);
      tick();
    end
    ref_valid = 1'b0; ref_base = 2'd0; #1;
    check("A_drain_arr", 32'({arr_T, arr_init, arr_stall, ref_ready, rd_ready}), 0);
    check("A_drain_busy", 32'(busy), 1);
    wait_done(t0 + 18 + 8 + 2, "A");
    check("A_max_score", 32'(max_score), 7);
    check("A_max_pos", 32'(max_pos), 1);
    tick();
    check("A_done_width", 32'({done, busy}), 0);
    check("A_max_hold", 32'(max_score), 7);

    // Job B: ref_len=4, three-cycle read gap after 4 beats, scores 5,9,9,4.
    vtab = '{5, 9, 9, 4, 0, 0, 0, 0};
    ref_len = 16'd4; start = 1'b1; t0 = cyc;
    tick(); start = 1'b0;
    rd = '{2, 3, 1, 0, 2, 1, 3, 0};
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        for (int g = 0; g < 3; g++) begin
          rd_valid = 1'b0; rd_base = ~rd[4]; #1;
          check("B_gap_S", 32'(arr_S), 32'(rd[4]));
          check("B_gap_ctl", 32'({arr_stall, arr_store_S, rd_ready}), 7);
          tick();
        end
      end
      rd_valid = 1'b1; rd_base = rd[7-i]; #1;
      check("B_load_S", 32'(arr_S), 32'(rd[7-i]));
      check("B_load_stall", 32'(arr_stall), 0);
      tick();
    end
    rd_valid = 1'b0; #1;
    check("B_after_8_beats", 32'({rd_ready, ref_ready}), 1);
    for (int i = 0; i < 4; i++) begin
      ref_valid = 1'b1; ref_base = 2'(i); #1;
      check("B_stream_T", 32'(arr_T), i);
      tick();
    end
    ref_valid = 1'b0;
    wait_done(t0 + 18 + 4 + 3, "B");
    check("B_max_score", 32'(max_score), 9);
    check("B_max_pos", 32'(max_pos), 1);
    tick();
    check("B_done_width", 32'(done), 0);

    // Job C: ref_len=0 ends right after the load.
    ref_len = 16'd0; start = 1'b1; t0 = cyc;
    tick(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_valid = 1'b1; rd_base = 2'(i); tick();
    end
    rd_valid = 1'b0;
    wait_done(t0 + 9, "C");
    check("C_max_score", 32'(max_score), 0);
    check("C_max_pos", 32'(max_pos), 0);
    tick();

    // Job D: start while busy is ignored; reset mid-stream aborts without done.
    ref_len = 16'd4; start = 1'b1; t0 = cyc;
    tick(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin start = 1'b1; ref_len = 16'd0; end
      else start = 1'b0;
      rd_valid = 1'b1; rd_base = 2'd1; tick();
    end
    start = 1'b0; rd_valid = 1'b0; #1;
    check("D_start_ignored", 32'({rd_ready, ref_ready}), 1);
    for (int i = 0; i < 2; i++) begin
      ref_valid = 1'b1; ref_base = 2'd2; tick();
    end
    rst = 1'b1; tick();
    rst = 1'b0; ref_valid = 1'b0; #1;
    check("D_reset_abort", 32'({busy, done, ref_ready, arr_init, arr_stall}), 0);
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check("D_no_done", done_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sw_array_seq.md
# sw_array_seq

Sequencer for a linear systolic array of NUM_PE Smith-Waterman PEs (affine gap). It loads the short read into the array's S chain, streams reference bases with init marking, and freezes the array with stall whenever input data is missing. It also drains the pipeline and tracks the best last-PE score and its reference position. It sits between the read/reference input streams and PE0, and observes the outputs of the last PE.

## Interface
- NUM_PE, 8, PEs in the chain; the read length is exactly NUM_PE
- SCORE_WIDTH, 10, width of V/F
- REF_LEN_W, 16, width of ref length and position counters
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a job; sampled only in IDLE
- ref_len  in  REF_LEN_W  reference bases in this job; latched on start
- rd_valid / rd_base / rd_ready  in / in / out  1 / 2 / 1  read-base stream
- ref_valid / ref_base / ref_ready  in / in / out  1 / 2 / 1  reference-base stream
- arr_S, arr_store_S  out  2, 1  to PE0 S_in, store_S_in
- arr_T, arr_init  out  2, 1  to PE0 T_in, init_in
- arr_V_in, arr_F_in  out  SCORE_WIDTH each  to PE0 V_in, F_in; constant 0
- arr_stall  out  1  to every PE stall
- arr_V_last, arr_init_last  in  SCORE_WIDTH, 1  last PE V_out, init_out
- busy  out  1  high from LOAD through DRAIN
- done  out  1  one-cycle pulse at job end
- max_score  out  SCORE_WIDTH  best arr_V_last of the job
- max_pos  out  REF_LEN_W  reference index of max_score

## Operation
- IDLE: ready signals 0, array outputs 0. When start=1, latch ref_len, clear the counters and the tracker, go to LOAD.
- LOAD: rd_ready=1. Each accepted beat drives arr_S=rd_base, arr_store_S=1, arr_stall=0.
  - Read bases arrive in the order read[NUM_PE-1] down to read[0].
  - Array contract: after NUM_PE contiguous unstalled store beats, PE k holds read[k].
  - If rd_valid=0, hold arr_S and arr_store_S=1, and assert arr_stall=1 so the S chain freezes.
  - After the NUM_PE-th beat, go to STREAM. If ref_len=0, go to DONE instead.
- STREAM: ref_ready=1. Each accepted beat drives arr_T=ref_base, arr_init=1, arr_store_S=0, arr_stall=0.
  - If ref_valid=0, hold arr_T and arr_init and assert arr_stall=1.
  - After ref_len beats, go to DRAIN.
- DRAIN: arr_T=0, arr_init=0, arr_stall=0. Stay until ref_len valid outputs have been counted, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Output capture: a last-PE output is sampled only when arr_init_last=1 and arr_stall=0.
  - The j-th sampled output is reference index j, counted from 0.
  - Its value is compared unsigned against max_score. Update only on strictly greater, so the earliest position wins ties.
- max_score and max_pos hold their values from DONE until the next start is accepted.
- start while busy is ignored.

## Timing
- Reset: state IDLE, and every output is 0 (busy, done, ready signals, arr_* signals, max_score, max_pos).
- A reset mid-job aborts immediately, with no done pulse.
- start accepted at cycle t gives LOAD at t+1.
- Pipeline: the last-PE output for the reference beat issued at unstalled cycle c appears at cycle c+NUM_PE. Stalled cycles add one cycle each.
- With no stalls, done is at t + 1 + NUM_PE + ref_len + NUM_PE + 1.
- Stalling in STREAM also stops the output counter. A stall cycle never counts as a valid output.
- The controller never stalls in DRAIN.
- The counters compare with == against the latched ref_len. ref_len is at most 2^REF_LEN_W-1, so no counter wraps.

## Structure
- Package sw_pkg holds:
  - base_t (2-bit; A=00, C=01, G=10, T=11)
  - the state enum {IDLE, LOAD, STREAM, DRAIN, DONE}
  - SCORE_WIDTH and REF_LEN_W defaults
- Sub-module sw_max_tracker holds the compare/update logic for max_score and max_pos, plus the reference index counter. Its inputs are clear, sample_en and V.
- The FSM and the beat counters live in sw_array_seq.

## Test plan
- Reset check: hold rst for 2 cycles, with start=1 also driven -> all outputs 0 and no busy. Release rst with start=1 -> LOAD next cycle.
- Load order, NUM_PE=8, read 0,1,0,1,3,0 padded to 8 bases -> arr_S emits read[7]..read[0] on consecutive cycles with arr_store_S=1.
- Load with a gap: drop rd_valid for 3 cycles mid-load -> arr_stall=1 for exactly those 3 cycles, arr_S holds, and the beat count stays 8.
- Stream stall: ref_len=8, reference 0,1,0,2,0,1,3,0, with ref_valid low for 2 cycles after beat 3 -> arr_stall=1 for those 2 cycles, arr_T held, and done delayed by exactly 2 cycles.
- Max tracking: model arr_V_last/arr_init_last returning 5,9,9,4 for ref_len=4 -> max_score=9, max_pos=1, done pulse of width 1, busy falls with done.
- Edge cases: ref_len=0 -> done right after LOAD with max_score=0 and max_pos=0. Reset asserted during STREAM -> IDLE next cycle with no done. start during busy -> ignored.
